mem_arbiter: RTL and testbench

Shares the single backing-memory burst port between the icache refill path and the dcache refill/write-back path. It sits below u_icache and u_dcache in top, and its output port goes to the external memory/bus model. It sequences one transaction at a time through a request/ack/beat handshake. Fixed priority goes to dcache, with a starvation guard so icache refills always make progress while pipeline_en is stalled on a miss.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_prio.sv | 48 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   state_e     : transaction sequencer states
//   owner_e     : which cache currently owns the memory port
//   burst_off_w : number of low address bits covered by one burst
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2
  } owner_e;

  // Byte-offset width of one whole burst (BURST_LEN beats of DATA_W bits).
  function automatic int burst_off_w(input int burst_len, input int data_w);
    return $clog2(burst_len * data_w / 8);
  endfunction

endpackage

// File: rtl/arb_prio.sv
// Winner selection between icache and dcache plus the starvation counter.
//   clk, rst        : clock, asynchronous active-low reset
//   ic_req, dc_req  : pending requests from the two caches
//   arb_en          : high while the sequencer is idle and arbitrating
//   win_ic, win_dc  : one-hot winner for this cycle (both 0 if nobody asks)
// dcache has fixed priority; once it has won STARVE_MAX times in a row
// while icache was waiting, icache takes the next grant.
module arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ic_req,
  input  logic dc_req,
  input  logic arb_en,
  output logic win_ic,
  output logic win_dc
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  always_comb begin
    starved  = (starve_q == CNT_W'(STARVE_MAX));
    win_ic   = arb_en && ic_req && (!dc_req || starved);
    win_dc   = arb_en && dc_req && !win_ic;
    starve_d = starve_q;
    if (arb_en) begin
      // Any cycle where icache is not waiting, or where it wins, ends the run.
      if (!ic_req || win_ic) begin
        starve_d = '0;
      end else if (win_dc && !starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one burst memory port between icache refills and dcache
// refills/write-backs, one transaction at a time.
//   ic_*       : icache refill request, grant, read beats, done pulse
//   dc_*       : dcache request (we selects write-back), grant, read beats,
//                write-beat consumed strobe, done pulse
//   mem_*      : memory side: req/ack, burst-aligned address, beats
//   busy       : sequencer is not idle
//   dbg_state  : current sequencer state (state_e encoding)
// Handshake: mem_req stays high from the cycle after arbitration until
// the cycle mem_ack is seen; a beat transfers in any DATA cycle where the
// memory strobe of the latched direction (mem_rvalid for reads, mem_wready
// for writes) is high; the owner sees done for exactly one cycle after
// the last beat.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int OFF_W  = burst_off_w(BURST_LEN, DATA_W);
  localparam int BEAT_W = $clog2(BURST_LEN);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                arb_en, win_ic, win_dc;
  logic                in_data, rd_beat, wr_beat, beat;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_arb_prio (
    .clk    (clk),
    .rst    (rst),
    .ic_req (ic_req),
    .dc_req (dc_req),
    .arb_en (arb_en),
    .win_ic (win_ic),
    .win_dc (win_dc)
  );

  assign arb_en  = (state_q == ST_IDLE);
  assign in_data = (state_q == ST_DATA);
  // Strobes of the wrong direction for the latched burst are ignored.
  assign rd_beat = in_data && !we_q && mem_rvalid;
  assign wr_beat = in_data &&  we_q && mem_wready;
  assign beat    = rd_beat || wr_beat;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_ic) begin
          owner_d = OWN_IC;
          we_d    = 1'b0;
          addr_d  = {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = ST_REQ;
        end else if (win_dc) begin
          owner_d = OWN_DC;
          we_d    = dc_we;
          addr_d  = {dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = ST_DONE;
          end
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign ic_gnt    = busy && (owner_q == OWN_IC);
  assign dc_gnt    = busy && (owner_q == OWN_DC);
  assign ic_rvalid = rd_beat && (owner_q == OWN_IC);
  assign dc_rvalid = rd_beat && (owner_q == OWN_DC);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  // we_q is only ever set for a dcache owner.
  assign dc_wready = wr_beat;
  assign mem_wdata = (in_data && we_q) ? dc_wdata : '0;
  assign ic_done   = (state_q == ST_DONE) && (owner_q == OWN_IC);
  assign dc_done   = (state_q == ST_DONE) && (owner_q == OWN_DC);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table rounds, hand-written
// starvation/reset sequences and randomized rounds against a
// transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BURST_LEN  = 4;
  localparam int STARVE_MAX = 4;
  localparam int IC = 1;
  localparam int DC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_req, dc_req, dc_we;
  logic [ADDR_W-1:0] ic_addr, dc_addr, mem_addr;
  logic [DATA_W-1:0] dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
  logic              ic_gnt, ic_rvalid, ic_done;
  logic              dc_wready, dc_gnt, dc_rvalid, dc_done;
  logic              mem_req, mem_we, mem_ack, mem_wready, mem_rvalid, busy;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int starve_m = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wready(dc_wready), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_wdata(mem_wdata), .mem_wready(mem_wready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Arbitration at transaction level: dcache first unless icache has
  // already been passed over STARVE_MAX times in a row.
  function automatic int model_arb(input bit ic_p, input bit dc_p);
    int w;
    if (ic_p && dc_p && starve_m != STARVE_MAX) begin
      w = DC;
      starve_m = starve_m + 1;
    end else if (ic_p) begin
      w = IC;
      starve_m = 0;
    end else begin
      w = DC;
      starve_m = 0;
    end
    return w;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a - (a % (BURST_LEN * DATA_W / 8));
  endfunction

  function automatic logic [1:0] gnt_of(input int who);
    return (who == IC) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_flags"}, {busy, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_done, dc_done,
                          mem_req, mem_we, dc_wready}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, ic_rdata | dc_rdata | mem_wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- driver: one transaction ----------------
  // Entered at the drive point of the IDLE arbitration cycle (requests
  // already applied); returns at the drive point of the following IDLE cycle.
  task automatic serve(input int who, input logic we, input logic [31:0] exp_addr,
                       input int lat, input logic [15:0] pat, input int pat_len,
                       input logic [31:0] base, input bit keep);
    int beats = 0;
    int cyc = 0;
    logic b;
    logic [31:0] d, wd;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_gnt", {ic_gnt, dc_gnt}, 0);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_fwd", {ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}, 0);
    for (int k = 0; k <= lat; k++) begin
      tick();
      mem_ack    = (k == lat);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_wready = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("req_mem_req", mem_req, 1);
      chk("req_addr", mem_addr, exp_addr);
      chk("req_we", mem_we, we);
      chk("req_gnt", {ic_gnt, dc_gnt}, gnt_of(who));
      chk("req_fwd", {ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}, 0);
    end
    while (beats < BURST_LEN && cyc < 200) begin
      tick();
      mem_ack = 1'b0;
      b  = (cyc < pat_len) ? pat[cyc] : ($urandom_range(0, 99) < 60);
      d  = base + beats;
      wd = $urandom;
      if (we) begin
        mem_wready = b;
        dc_wdata   = wd;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
      end else begin
        mem_rvalid = b;
        mem_rdata  = d;
        mem_wready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("data_mem_req", mem_req, 0);
      chk("data_gnt", {ic_gnt, dc_gnt}, gnt_of(who));
      chk("data_done", {ic_done, dc_done}, 0);
      if (we) begin
        chk("wr_wready", dc_wready, b);
        chk("wr_no_rvalid", {ic_rvalid, dc_rvalid}, 0);
        if (b) chk("wr_wdata", mem_wdata, wd);
      end else begin
        chk("rd_rvalid", {ic_rvalid, dc_rvalid}, b ? gnt_of(who) : 2'b00);
        chk("rd_wready", dc_wready, 0);
        if (b) chk("rd_data", (who == IC) ? ic_rdata : dc_rdata, d);
      end
      if (b) beats++;
      cyc++;
    end
    if (beats < BURST_LEN) chk("data_timeout", beats, BURST_LEN);
    tick();
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_wready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_pulse", {ic_done, dc_done}, gnt_of(who));
    chk("done_gnt", {ic_gnt, dc_gnt}, gnt_of(who));
    chk("done_fwd", {ic_rvalid, dc_rvalid, dc_wready, mem_req}, 0);
    tick();
    if (!keep) begin
      if (who == IC) ic_req = 1'b0;
      else           dc_req = 1'b0;
    end
    mem_rvalid = 1'b1;
    mem_wready = 1'b1;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("quiet_busy", busy, 0);
    chk("quiet_out", {ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_done, dc_done, mem_req, dc_wready}, 0);
    starve_m = 0;
    tick();
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          ic_on;
    bit          dc_on;
    bit          we;
    logic [31:0] ic_a;
    logic [31:0] dc_a;
    int          lat;
    logic [15:0] pat;
    int          pat_len;
    logic [31:0] base;
    int          first;   // 0: take the winner from the model
    logic [31:0] ic_exp;
    logic [31:0] dc_exp;
  } vec_t;

  task automatic run_round(input vec_t v);
    int w1, w2;
    ic_req = v.ic_on; dc_req = v.dc_on; dc_we = v.we;
    ic_addr = v.ic_a; dc_addr = v.dc_a;
    mem_rvalid = 1'b1; mem_wready = 1'b1;
    w1 = model_arb(v.ic_on, v.dc_on);
    if (v.first != 0) w1 = v.first;
    serve(w1, (w1 == DC) ? v.we : 1'b0, (w1 == IC) ? v.ic_exp : v.dc_exp,
          v.lat, v.pat, v.pat_len, v.base, 1'b0);
    if (v.ic_on && v.dc_on) begin
      w2 = model_arb(w1 == DC, w1 == IC);
      serve(w2, (w2 == DC) ? v.we : 1'b0, (w2 == IC) ? v.ic_exp : v.dc_exp,
            v.lat, v.pat, v.pat_len, v.base + 32'h10, 1'b0);
    end
    idle_check();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[5];
    vec_t rv;
    int   st_who[7];
    bit   st_keep[7];

    vecs[0] = '{1, 0, 0, 32'h1004, 32'h0,        1, 16'h000F, 4, 32'hA0, IC, 32'h1000,     32'h0};
    vecs[1] = '{1, 1, 0, 32'h3008, 32'h2000,     0, 16'h000F, 4, 32'h50, DC, 32'h3000,     32'h2000};
    vecs[2] = '{0, 1, 1, 32'h0,    32'h400C,     2, 16'h0065, 7, 32'h0,  DC, 32'h0,        32'h4000};
    vecs[3] = '{1, 1, 1, 32'h5FFC, 32'h6010,     0, 16'h0000, 0, 32'h70, DC, 32'h5FF0,     32'h6010};
    vecs[4] = '{0, 1, 0, 32'h0,    32'hFFFFFFFF, 3, 16'h0000, 0, 32'h90, DC, 32'h0,        32'hFFFFFFF0};
    st_who  = '{DC, DC, DC, DC, IC, DC, IC};
    st_keep = '{1, 1, 1, 1, 1, 0, 0};

    // Reset with requests and stray beats present: everything stays 0.
    rst = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1;
    ic_addr = 32'h1234; dc_addr = 32'h5678; dc_wdata = 32'hDEADBEEF;
    mem_ack = 1'b1; mem_wready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    tick();
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    mem_ack = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0;
    rst = 1'b1;
    starve_m = 0;
    tick();

    for (int i = 0; i < 5; i++) run_round(vecs[i]);

    // Starvation: icache held, dcache re-requesting back to back.
    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
    ic_addr = 32'h9004; dc_addr = 32'h8008;
    for (int i = 0; i < 7; i++) begin
      void'(model_arb(ic_req, dc_req));
      serve(st_who[i], 1'b0, (st_who[i] == IC) ? 32'h9000 : 32'h8000,
            i % 3, 16'h0, 0, 32'h100 * i, st_keep[i]);
    end
    idle_check();

    // Reset in the middle of an icache burst, then a fresh burst.
    ic_req = 1'b1; ic_addr = 32'h7008; dc_req = 1'b0;
    void'(model_arb(1'b1, 1'b0));
    @(negedge clk);
    tick();
    mem_ack = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_seq_req", mem_req, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0 + i;
      @(negedge clk);
      chk("rst_seq_beat", ic_rvalid, 1);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hB2;
    #1;
    chk("rst_seq_pre", ic_rvalid, 1);
    rst = 1'b0;
    #1;
    chk_quiet("rst_async");
    starve_m = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_quiet("rst_hold");
      tick();
    end
    rst = 1'b1;
    void'(model_arb(1'b1, 1'b0));
    serve(IC, 1'b0, 32'h7000, 1, 16'h000F, 4, 32'hC0, 1'b0);
    idle_check();

    // Randomized rounds against the model.
    for (int r = 0; r < 30; r++) begin
      rv.ic_on   = 1'($urandom_range(0, 1));
      rv.dc_on   = rv.ic_on ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.we      = 1'($urandom_range(0, 1));
      rv.ic_a    = $urandom;
      rv.dc_a    = $urandom;
      rv.lat     = $urandom_range(0, 3);
      rv.pat     = 16'h0;
      rv.pat_len = 0;
      rv.base    = $urandom;
      rv.first   = 0;
      rv.ic_exp  = align(rv.ic_a);
      rv.dc_exp  = align(rv.dc_a);
      run_round(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
